sound_event_scheduler: RTL and testbench

- Sits between the game-event sources (ball hit, bonus, level-up, game-over) and the sound player FSM.
- Captures one-cycle event pulses into a pending set and grants one event at a time to the player by fixed priority, using a valid/ack handshake.
- Enforces a frame-counted silence gap between sounds.
- Lets selected high-priority events abort a sound that is already playing.

---
 rtl/sound_event_scheduler_pkg.sv | 24 ++
 rtl/sound_event_scheduler_prio.sv | 24 ++
 rtl/sound_event_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sound_event_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_event_scheduler_pkg.sv
// Shared definitions for the sound subsystem: event indices, widths shared
// with the sound player, and the scheduler state encoding.
package sound_pkg;

  // Event sources, index 0 is the lowest priority
  localparam int unsigned EVT_HIT      = 0;
  localparam int unsigned EVT_BONUS    = 1;
  localparam int unsigned EVT_LEVELUP  = 2;
  localparam int unsigned EVT_GAMEOVER = 3;

  // Widths shared with the sound player
  localparam int unsigned SND_NUM_EVT = 4;
  localparam int unsigned SND_ID_W    = 2;
  localparam int unsigned SND_TONE_W  = 10;

  // Scheduler control states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_PLAYING = 2'd2,
    ST_GAP     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sound_event_scheduler_prio.sv
// Priority encoder: reports whether any bit is set and the index of the
// highest set bit.
module prio_encoder_msb #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Later (higher) indices overwrite earlier ones, leaving the MSB winner
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sound_event_scheduler.sv
// Sound event scheduler: collects one-cycle game event pulses into a pending
// set, offers the highest-priority one to the sound player over a valid/ack
// handshake, enforces a frame-counted silence gap after each sound, and lets
// selected events abort a lower-priority sound in progress.
module sound_event_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned          NUM_EVT      = SND_NUM_EVT,
  parameter int unsigned          ID_W         = SND_ID_W,
  parameter int unsigned          GAP_FRAMES   = 2,
  parameter logic [NUM_EVT-1:0]   PREEMPT_MASK = 4'b1000,
  parameter int unsigned          CNT_W        = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [NUM_EVT-1:0] req,
  input  logic               mute,
  input  logic               play_ack,
  input  logic               player_done,
  output logic               play_valid,
  output logic [ID_W-1:0]    play_id,
  output logic               abort,
  output logic [NUM_EVT-1:0] pending,
  output logic [CNT_W-1:0]   coalesce_cnt
);

  localparam int unsigned GAP_W = (GAP_FRAMES > 0) ? $clog2(GAP_FRAMES + 1) : 1;
  localparam int unsigned MRG_W = $clog2(NUM_EVT + 1);

  sched_state_t state, state_nx;

  logic [GAP_W-1:0]   gap_cnt;
  logic               grant;
  logic [NUM_EVT-1:0] pending_nx;
  logic [MRG_W-1:0]   merge_cnt;
  logic [CNT_W:0]     cnt_sum;
  logic [CNT_W-1:0]   coalesce_nx;
  logic [NUM_EVT-1:0] above_mask;
  logic [NUM_EVT-1:0] preempt_vec;
  logic               top_found;
  logic [ID_W-1:0]    top_id;
  logic               preempt;
  logic [ID_W-1:0]    preempt_id;
  logic               abort_nx;
  logic               load_offer;
  logic               gap_load;

  // Highest pending event: candidate for the next offer
  prio_encoder_msb #(
    .N     (NUM_EVT),
    .IDX_W (ID_W)
  ) u_top_sel (
    .vec   (pending),
    .found (top_found),
    .idx   (top_id)
  );

  // Any preempt-capable pending event ranked above the sound now playing
  prio_encoder_msb #(
    .N     (NUM_EVT),
    .IDX_W (ID_W)
  ) u_preempt_sel (
    .vec   (preempt_vec),
    .found (preempt),
    .idx   (preempt_id)
  );

  // Mask of event indices strictly above the current play_id
  always_comb begin
    above_mask = '0;
    for (int unsigned i = 0; i < NUM_EVT; i++) begin
      above_mask[i] = (ID_W'(i) > play_id);
    end
  end

  assign preempt_vec = pending & PREEMPT_MASK & above_mask;

  // Handshake completes only in OFFER; mute overrides an ack in the same cycle
  assign grant = (state == ST_OFFER) && play_ack && !mute;

  // Next pending set and number of requests merged into already-pending bits.
  // A request for the bit being granted re-arms it rather than merging.
  always_comb begin
    pending_nx = pending;
    merge_cnt  = '0;
    if (mute) begin
      pending_nx = '0;
    end else begin
      if (grant) begin
        pending_nx[play_id] = 1'b0;
      end
      for (int unsigned i = 0; i < NUM_EVT; i++) begin
        if (req[i]) begin
          if (pending[i] && !(grant && (play_id == ID_W'(i)))) begin
            merge_cnt = merge_cnt + MRG_W'(1);
          end
          pending_nx[i] = 1'b1;
        end
      end
    end
  end

  // Saturating accumulation of merged requests
  always_comb begin
    cnt_sum = {1'b0, coalesce_cnt} + (CNT_W + 1)'(merge_cnt);
    if (cnt_sum[CNT_W]) begin
      coalesce_nx = '1;
    end else begin
      coalesce_nx = cnt_sum[CNT_W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; mute dominates, and player_done beats a preempt
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (!mute && top_found) state_nx = ST_OFFER;
      end
      ST_OFFER: begin
        if (mute)          state_nx = ST_IDLE;
        else if (play_ack) state_nx = ST_PLAYING;
      end
      ST_PLAYING: begin
        if (mute)             state_nx = ST_IDLE;
        else if (player_done) state_nx = (GAP_FRAMES > 0) ? ST_GAP : ST_IDLE;
        else if (preempt)     state_nx = ST_IDLE;
      end
      ST_GAP: begin
        if (mute || (gap_cnt == '0)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output and datapath control decoded from state
  always_comb begin
    play_valid = (state == ST_OFFER);
    abort_nx   = (state == ST_PLAYING) && (mute || (!player_done && preempt));
    load_offer = (state == ST_IDLE) && (state_nx == ST_OFFER);
    gap_load   = (state == ST_PLAYING) && !mute && player_done;
  end

  // Datapath registers: pending set, counter, offered id, abort pulse, gap timer
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending      <= '0;
      coalesce_cnt <= '0;
      play_id      <= '0;
      abort        <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      pending      <= pending_nx;
      coalesce_cnt <= coalesce_nx;
      abort        <= abort_nx;
      if (load_offer) begin
        play_id <= top_id;
      end
      if (gap_load) begin
        gap_cnt <= GAP_W'(GAP_FRAMES);
      end else if ((state == ST_GAP) && startOfFrame && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // A preempting event always ranks above the sound it interrupts
  assert property (@(posedge clk) disable iff (!resetN) preempt |-> (preempt_id > play_id));

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed self-checking bench for sound_event_scheduler.
module tb_sound_event_scheduler;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic [3:0] req;
  logic       mute;
  logic       play_ack;
  logic       player_done;
  logic       play_valid;
  logic [1:0] play_id;
  logic       abort;
  logic [3:0] pending;
  logic [7:0] coalesce_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_cnt = '0;

  sound_event_scheduler #(
    .NUM_EVT      (4),
    .ID_W         (2),
    .GAP_FRAMES   (2),
    .PREEMPT_MASK (4'b1000),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .req          (req),
    .mute         (mute),
    .play_ack     (play_ack),
    .player_done  (player_done),
    .play_valid   (play_valid),
    .play_id      (play_id),
    .abort        (abort),
    .pending      (pending),
    .coalesce_cnt (coalesce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [3:0] v);
    req = v;
    tick();
    req = '0;
  endtask

  task automatic do_ack();
    play_ack = 1'b1;
    tick();
    play_ack = 1'b0;
  endtask

  // done pulse, two frame pulses, then the GAP->IDLE and IDLE->OFFER cycles
  task automatic finish_sound();
    player_done = 1'b1;
    tick();
    player_done = 1'b0;
    startOfFrame = 1'b1;
    tick();
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0; startOfFrame = 1'b0; req = '0; mute = 1'b0;
    play_ack = 1'b0; player_done = 1'b0;
    tick(); tick();
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", play_valid); end
    n_tests++; if (play_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", play_id); end
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort got=%0b exp=0", abort); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    n_tests++; if (coalesce_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", coalesce_cnt); end
    resetN = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_single();
    pulse_req(4'b0001);
    n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL single_pend got=%b exp=0001", pending); end
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1 got=%0b exp=0", play_valid); end
    tick();
    n_tests++; if (play_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0b exp=1", play_valid); end
    n_tests++; if (play_id !== 2'd0) begin n_fail++; $display("FAIL single_id got=%0d exp=0", play_id); end
    tick();
    n_tests++; if (play_valid !== 1'b1) begin n_fail++; $display("FAIL single_hold got=%0b exp=1", play_valid); end
    do_ack();
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL single_ackv got=%0b exp=0", play_valid); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_ackp got=%b exp=0000", pending); end
    tick();
    finish_sound();
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%0b exp=0", play_valid); end
  endtask

  task automatic test_priority();
    pulse_req(4'b0101);
    n_tests++; if (pending !== 4'b0101) begin n_fail++; $display("FAIL prio_pend got=%b exp=0101", pending); end
    tick();
    n_tests++; if (play_id !== 2'd2 || play_valid !== 1'b1) begin n_fail++; $display("FAIL prio_first got=%0d/%0b exp=2/1", play_id, play_valid); end
    do_ack();
    n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL prio_ackp got=%b exp=0001", pending); end
    player_done = 1'b1; tick(); player_done = 1'b0;
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap0 got=%0b exp=0", play_valid); end
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    tick();
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap1 got=%0b exp=0", play_valid); end
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap2 got=%0b exp=0", play_valid); end
    tick();
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL prio_idle got=%0b exp=0", play_valid); end
    tick();
    n_tests++; if (play_valid !== 1'b1 || play_id !== 2'd0) begin n_fail++; $display("FAIL prio_second got=%0d/%0b exp=0/1", play_id, play_valid); end
    n_tests++; if (coalesce_cnt !== 8'd0) begin n_fail++; $display("FAIL prio_cnt got=%0d exp=0", coalesce_cnt); end
    do_ack();
  endtask

  task automatic test_coalesce();
    pulse_req(4'b0001);
    n_tests++; if (coalesce_cnt !== 8'd0) begin n_fail++; $display("FAIL coal_first got=%0d exp=0", coalesce_cnt); end
    tick();
    pulse_req(4'b0001);
    n_tests++; if (coalesce_cnt !== 8'd1) begin n_fail++; $display("FAIL coal_second got=%0d exp=1", coalesce_cnt); end
    pulse_req(4'b0001);
    n_tests++; if (coalesce_cnt !== 8'd2) begin n_fail++; $display("FAIL coal_third got=%0d exp=2", coalesce_cnt); end
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL coal_abort got=%0b exp=0", abort); end
    finish_sound();
    n_tests++; if (play_valid !== 1'b1 || play_id !== 2'd0) begin n_fail++; $display("FAIL coal_reoffer got=%0d/%0b exp=0/1", play_id, play_valid); end
    do_ack();
    finish_sound();
    n_tests++; if (play_valid !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL coal_drain got=%0b/%b exp=0/0000", play_valid, pending); end
    exp_cnt = 8'd2;
  endtask

  task automatic test_preempt();
    pulse_req(4'b0010);
    tick();
    n_tests++; if (play_valid !== 1'b1 || play_id !== 2'd1) begin n_fail++; $display("FAIL pre_offer got=%0d/%0b exp=1/1", play_id, play_valid); end
    pulse_req(4'b0100);
    n_tests++; if (play_id !== 2'd1 || pending !== 4'b0110) begin n_fail++; $display("FAIL pre_norearb got=%0d/%b exp=1/0110", play_id, pending); end
    do_ack();
    n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL pre_ackp got=%b exp=0100", pending); end
    tick(); tick();
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL pre_unmasked got=%0b exp=0", abort); end
    pulse_req(4'b1000);
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL pre_early got=%0b exp=0", abort); end
    tick();
    n_tests++; if (abort !== 1'b1) begin n_fail++; $display("FAIL pre_pulse got=%0b exp=1", abort); end
    tick();
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL pre_width got=%0b exp=0", abort); end
    n_tests++; if (play_valid !== 1'b1 || play_id !== 2'd3) begin n_fail++; $display("FAIL pre_nogap got=%0d/%0b exp=3/1", play_id, play_valid); end
    do_ack();
    n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL pre_noreoffer got=%b exp=0100", pending); end
    finish_sound();
    n_tests++; if (play_valid !== 1'b1 || play_id !== 2'd2) begin n_fail++; $display("FAIL pre_next got=%0d/%0b exp=2/1", play_id, play_valid); end
    do_ack();
    finish_sound();
  endtask

  task automatic test_mute();
    pulse_req(4'b0110);
    tick();
    n_tests++; if (play_valid !== 1'b1 || play_id !== 2'd2) begin n_fail++; $display("FAIL mute_offer got=%0d/%0b exp=2/1", play_id, play_valid); end
    mute = 1'b1;
    tick();
    n_tests++; if (play_valid !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL mute_drop got=%0b/%b exp=0/0000", play_valid, pending); end
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL mute_noabort got=%0b exp=0", abort); end
    pulse_req(4'b1111);
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL mute_ignore got=%b exp=0000", pending); end
    n_tests++; if (coalesce_cnt !== exp_cnt) begin n_fail++; $display("FAIL mute_cnt got=%0d exp=%0d", coalesce_cnt, exp_cnt); end
    mute = 1'b0;
    tick(); tick();
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL mute_after got=%0b exp=0", play_valid); end
    pulse_req(4'b0001);
    tick();
    do_ack();
    mute = 1'b1;
    tick();
    n_tests++; if (abort !== 1'b1) begin n_fail++; $display("FAIL mute_playabort got=%0b exp=1", abort); end
    tick();
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL mute_playonce got=%0b exp=0", abort); end
    mute = 1'b0;
    tick();
  endtask

  task automatic test_done_vs_preempt();
    pulse_req(4'b0010);
    tick();
    do_ack();
    tick();
    pulse_req(4'b1000);
    n_tests++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL dvp_pend got=%b exp=1000", pending); end
    player_done = 1'b1; tick(); player_done = 1'b0;
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL dvp_noabort got=%0b exp=0", abort); end
    tick();
    n_tests++; if (abort !== 1'b0 || play_valid !== 1'b0) begin n_fail++; $display("FAIL dvp_gap got=%0b/%0b exp=0/0", abort, play_valid); end
    startOfFrame = 1'b1; tick(); tick(); startOfFrame = 1'b0;
    tick();
    n_tests++; if (play_valid !== 1'b0) begin n_fail++; $display("FAIL dvp_idle got=%0b exp=0", play_valid); end
    tick();
    n_tests++; if (play_valid !== 1'b1 || play_id !== 2'd3) begin n_fail++; $display("FAIL dvp_offer got=%0d/%0b exp=3/1", play_id, play_valid); end
    do_ack();
    finish_sound();
  endtask

  task automatic test_reset_mid();
    pulse_req(4'b0100);
    pulse_req(4'b0100);
    n_tests++; if (play_valid !== 1'b1 || coalesce_cnt !== exp_cnt + 8'd1) begin n_fail++; $display("FAIL rmid_pre got=%0b/%0d exp=1/%0d", play_valid, coalesce_cnt, exp_cnt + 8'd1); end
    #2 resetN = 1'b0;
    #1;
    n_tests++; if (play_valid !== 1'b0 || play_id !== 2'd0 || abort !== 1'b0 || pending !== 4'b0000 || coalesce_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rmid_async got=%0b/%0d/%0b/%b/%0d exp=0/0/0/0000/0", play_valid, play_id, abort, pending, coalesce_cnt);
    end
    exp_cnt = 8'd0;
    tick();
    resetN = 1'b1;
    tick();
    n_tests++; if (play_valid !== 1'b0 || abort !== 1'b0) begin n_fail++; $display("FAIL rmid_after got=%0b/%0b exp=0/0", play_valid, abort); end
  endtask

  task automatic test_saturate();
    pulse_req(4'b1000);
    tick();
    do_ack();
    pulse_req(4'b0001);
    req = 4'b0001;
    repeat (254) tick();
    n_tests++; if (coalesce_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got=%0d exp=254", coalesce_cnt); end
    tick();
    n_tests++; if (coalesce_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255 got=%0d exp=255", coalesce_cnt); end
    repeat (5) tick();
    n_tests++; if (coalesce_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", coalesce_cnt); end
    req = '0;
    n_tests++; if (abort !== 1'b0) begin n_fail++; $display("FAIL sat_noabort got=%0b exp=0", abort); end
    mute = 1'b1; tick(); mute = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_coalesce();
    test_preempt();
    test_mute();
    test_done_vs_preempt();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
